module_tick_timer: RTL
======================

Name: module_tick_timer

Overview:
Parametrised, multi-channel successor to the fixed millisecond counter. A prescaler divides clk down to a configurable tick rate and drives a free-running, loadable, gateable tick counter. CHANNELS compare units each raise a sticky interrupt flag when the counter reaches their compare value. Sits on the system bus side as the core timebase and timer-interrupt source.

Parameters:
TIMER_WIDTH, 32, width of tick counter, load and compare values.
CLK_FREQ_HZ, 50000000, frequency of clk in Hz.
TICK_HZ, 1000, counter increment rate in Hz. DIV = CLK_FREQ_HZ / TICK_HZ, integer division. Elaboration error if DIV < 1.
CHANNELS, 2, number of compare/interrupt channels, 1..8.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
en  in  1  count enable; gates the prescaler.
load  in  1  synchronous counter load strobe.
load_val  in  TIMER_WIDTH  value written to counter on load.
cmp_we  in  CHANNELS  per-channel compare register write strobe.
cmp_din  in  TIMER_WIDTH  shared compare write data.
irq_clr  in  CHANNELS  per-channel interrupt flag clear.
dout  out  TIMER_WIDTH  current tick count.
tick  out  1  one-cycle pulse, high in the cycle dout shows a new incremented value.
irq  out  CHANNELS  sticky per-channel match flags.

Behaviour:
- Reset asserted (low), asynchronous, no clock edge needed: prescaler=0, dout=0, tick=0, irq=0, all cmp registers = all-ones. Reset mid-count discards prescaler progress.
- Prescaler width = max(1, clog2(DIV)). Counts 0..DIV-1 on each edge with en=1. Holds its value with en=0.
- Increment event: en=1 and prescaler==DIV-1 and load=0. On that edge: prescaler->0, dout->dout+1 modulo 2^TIMER_WIDTH, tick->1. On every other edge tick->0.
- Wrap: all-ones +1 -> 0. No flag, no stall.
- DIV==1: dout increments on every enabled edge; tick stays high while en=1.
- load=1, highest priority, independent of en: dout->load_val, prescaler->0, tick->0, no increment that edge.
- Compare: for each channel i, irq[i] sets on the edge of an increment event where dout+1 == cmp[i] (modulo 2^TIMER_WIDTH). It rises together with dout.
- A load whose value equals cmp[i] never sets irq[i]. A cmp write whose value equals the current dout never sets irq[i].
- cmp_we[i]=1: cmp[i]->cmp_din on that edge. If a write and a matching increment fall on the same edge, the match uses the old cmp[i].
- irq_clr[i]=1 clears irq[i]. If set and clear fall on the same edge, set wins and irq[i] stays 1.
- Channels are fully independent. Multiple channels may share a compare value and set together.
- All outputs come directly from registers. No combinational path from inputs to outputs.

Test Plan:
1. CLK_FREQ_HZ=10000, TICK_HZ=1000 (DIV=10), release reset, en=1 -> dout increments exactly every 10 cycles; tick is high for one cycle with each new value; dout==5 after 50 cycles; a property checks dout==$past(dout)+1 at each tick.
2. en=1 for 4 cycles, then en=0 for 7 cycles, then en=1 -> first increment occurs 17 cycles after reset release; dout is constant while en=0.
3. load=1 with load_val=32'hFFFF_FFFE, en=1 -> prescaler restarts; after 10 cycles dout=32'hFFFF_FFFF; after 20 cycles dout=32'h0000_0000; no spurious tick on the load edge.
4. cmp0=3, cmp1=5, count from 0 -> irq[0] rises on the edge dout becomes 3 and stays high; pulse irq_clr[0] -> irq[0]=0. Assert irq_clr[1] on the edge dout becomes 5 -> irq[1]=1 (set wins).
5. cmp0=7, then load load_val=7 -> irq[0] stays 0. Write cmp0=dout+1 on the same edge as an increment to dout+1, with old cmp0 not equal to dout+1 -> irq[0] stays 0.
6. Mid-period with dout=9 and irq=2'b11, pulse reset low between clock edges -> dout=0, irq=0, tick=0 immediately; after release, first increment occurs a full DIV cycles later.

Source files
------------

// File: rtl/module_tick_timer.sv
// Prescaled tick counter with CHANNELS sticky compare-match interrupt flags.
// The prescaler gates increments of a loadable free-running counter; each channel flags when the count reaches its compare value.
module module_tick_timer #(
  parameter int unsigned TIMER_WIDTH = 32,
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned TICK_HZ     = 1000,
  parameter int unsigned CHANNELS    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   load,
  input  logic [TIMER_WIDTH-1:0] load_val,
  input  logic [CHANNELS-1:0]    cmp_we,
  input  logic [TIMER_WIDTH-1:0] cmp_din,
  input  logic [CHANNELS-1:0]    irq_clr,
  output logic [TIMER_WIDTH-1:0] dout,
  output logic                   tick,
  output logic [CHANNELS-1:0]    irq
);

  localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("module_tick_timer: CLK_FREQ_HZ / TICK_HZ must be at least 1");
  end
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("module_tick_timer: CHANNELS must be in 1..8");
  end

  logic [PW-1:0]          pre;
  logic [TIMER_WIDTH-1:0] cmp [CHANNELS];
  logic [TIMER_WIDTH-1:0] dout_nxt;
  logic                   inc;

  assign dout_nxt = dout + TIMER_WIDTH'(1);
  assign inc      = en && (pre == PRE_LAST) && !load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre  <= '0;
      dout <= '0;
      tick <= 1'b0;
    end else if (load) begin
      pre  <= '0;
      dout <= load_val;
      tick <= 1'b0;
    end else if (en) begin
      if (pre == PRE_LAST) begin
        pre  <= '0;
        dout <= dout_nxt;
        tick <= 1'b1;
      end else begin
        pre  <= pre + PW'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  // Match compares against the pre-write cmp value; a same-edge set beats clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) cmp[i] <= '1;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (cmp_we[i]) cmp[i] <= cmp_din;
        if (inc && (dout_nxt == cmp[i])) irq[i] <= 1'b1;
        else if (irq_clr[i])             irq[i] <= 1'b0;
      end
    end
  end

endmodule
